// File: rtl/pipeline_skid_register.sv
// Valid/ready elastic pipeline stage backed by a DEPTH-entry circular skid buffer.
// Optional feature macro: PIPELINE_FLUSH_ZERO_EN (flush zeroes entries, empty stage presents 0 on data_o).
module pipeline_skid_register #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       ready_i,
    input  logic                       flush_i,
    input  logic                       global_flush_i,
    input  logic                       global_stall_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic flush_s;
    logic push_s;
    logic pop_s;

    // Status flags are decoded purely from the occupancy register.
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == CW'(0));

    // Handshakes never look at the opposite side's ready/valid, so no combinational path crosses the stage.
    assign ready_o = rst_n & ~full_o & ~global_stall_i;
    assign valid_o = rst_n & ~empty_o & ~global_stall_i;

    assign flush_s = flush_i | global_flush_i;
    assign push_s  = valid_i & ready_o;
    assign pop_s   = valid_o & ready_i;

`ifdef PIPELINE_FLUSH_ZERO_EN
    assign data_o = empty_o ? '0 : mem_q[head_q];
`else
    assign data_o = mem_q[head_q];
`endif

    // Next-state for storage, pointers and occupancy; flush discards any same-cycle push/pop.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_s) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
`ifdef PIPELINE_FLUSH_ZERO_EN
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
`endif
        end else begin
            if (push_s) begin
                mem_d[tail_q] = data_i;
                tail_d        = ptr_next(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_next(head_q);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset clears pointers, count and every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed, table-driven bench for pipeline_skid_register at DEPTH = 2, 4 and 1.
module tb_pipeline_skid_register;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] data_i = 32'h0;
    logic        ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        global_flush_i = 1'b0;
    logic        global_stall_i = 1'b0;

    logic        ready_a, valid_a, full_a, empty_a;
    logic [31:0] data_a;
    logic [1:0]  count_a;
    logic        ready_b, valid_b, full_b, empty_b;
    logic [31:0] data_b;
    logic [2:0]  count_b;
    logic        ready_c, valid_c, full_c, empty_c;
    logic [31:0] data_c;
    logic [0:0]  count_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_skid_register #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_a), .valid_o(valid_a), .data_o(data_a), .ready_i(ready_i),
        .flush_i(flush_i), .global_flush_i(global_flush_i), .global_stall_i(global_stall_i),
        .count_o(count_a), .full_o(full_a), .empty_o(empty_a));

    pipeline_skid_register #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_b), .valid_o(valid_b), .data_o(data_b), .ready_i(ready_i),
        .flush_i(flush_i), .global_flush_i(global_flush_i), .global_stall_i(global_stall_i),
        .count_o(count_b), .full_o(full_b), .empty_o(empty_b));

    pipeline_skid_register #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_c), .valid_o(valid_c), .data_o(data_c), .ready_i(ready_i),
        .flush_i(flush_i), .global_flush_i(global_flush_i), .global_stall_i(global_stall_i),
        .count_o(count_c), .full_o(full_c), .empty_o(empty_c));

    // Selects which instance the current vector observes.
    logic [1:0]  sel = 2'd0;
    logic        o_rdy, o_vld, o_full, o_empty;
    logic [31:0] o_dat;
    logic [7:0]  o_cnt;
    int          o_depth;

    always_comb begin
        o_rdy = ready_a; o_vld = valid_a; o_dat = data_a; o_cnt = 8'(count_a);
        o_full = full_a; o_empty = empty_a; o_depth = 2;
        case (sel)
            2'd1: begin
                o_rdy = ready_b; o_vld = valid_b; o_dat = data_b; o_cnt = 8'(count_b);
                o_full = full_b; o_empty = empty_b; o_depth = 4;
            end
            2'd2: begin
                o_rdy = ready_c; o_vld = valid_c; o_dat = data_c; o_cnt = 8'(count_c);
                o_full = full_c; o_empty = empty_c; o_depth = 1;
            end
            default: begin
                o_rdy = ready_a; o_vld = valid_a; o_dat = data_a; o_cnt = 8'(count_a);
                o_full = full_a; o_empty = empty_a; o_depth = 2;
            end
        endcase
    end

    typedef struct {
        logic [1:0]  sel;
        logic        chk;
        logic        rst;
        logic        vld;
        logic [31:0] dat;
        logic        rdy;
        logic        fl;
        logic        gfl;
        logic        stl;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_cnt;
        logic        dc;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vecs[$];

    // Inputs: sel chk rst_n valid data ready flush gflush stall | expected: ready valid count data_dontcare data
    function automatic vec_t v(input int s, input int c, input int r, input int vl, input logic [31:0] d,
                               input int rd, input int f, input int gf, input int st,
                               input int er, input int ev, input int ec, input int dc, input logic [31:0] ed);
        vec_t x;
        x.sel = 2'(s); x.chk = (c != 0); x.rst = (r != 0); x.vld = (vl != 0); x.dat = d;
        x.rdy = (rd != 0); x.fl = (f != 0); x.gfl = (gf != 0); x.stl = (st != 0);
        x.e_rdy = (er != 0); x.e_vld = (ev != 0); x.e_cnt = 8'(ec); x.dc = (dc != 0); x.e_dat = ed;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pops;
        // DEPTH=2: reset, streaming, global stall.
        vecs.push_back(v(0,0,0,0,32'h0,0,0,0,0, 0,0,0,1,32'h0));
        vecs.push_back(v(0,1,0,1,32'hDEADBEEF,1,0,0,0, 0,0,0,0,32'h0));
        vecs.push_back(v(0,1,1,1,32'hCAFEBABE,1,0,0,0, 1,0,0,0,32'h0));
        vecs.push_back(v(0,1,1,1,32'h12345678,1,0,0,0, 1,1,1,0,32'hCAFEBABE));
        vecs.push_back(v(0,1,1,1,32'h0BADF00D,1,0,0,0, 1,1,1,0,32'h12345678));
        vecs.push_back(v(0,1,1,0,32'h0,1,0,0,0, 1,1,1,0,32'h0BADF00D));
        vecs.push_back(v(0,1,1,0,32'h0,1,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(0,1,1,1,32'hAAAA0001,0,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(0,1,1,1,32'hAAAA0002,0,0,0,0, 1,1,1,0,32'hAAAA0001));
        vecs.push_back(v(0,1,1,1,32'hAAAA0003,1,0,0,1, 0,0,2,0,32'hAAAA0001));
        vecs.push_back(v(0,1,1,1,32'hAAAA0003,1,0,0,1, 0,0,2,0,32'hAAAA0001));
        vecs.push_back(v(0,1,1,1,32'hAAAA0003,1,0,0,1, 0,0,2,0,32'hAAAA0001));
        vecs.push_back(v(0,1,1,0,32'h0,1,0,0,0, 0,1,2,0,32'hAAAA0001));
        vecs.push_back(v(0,1,1,0,32'h0,1,0,0,0, 1,1,1,0,32'hAAAA0002));
        vecs.push_back(v(0,1,1,0,32'h0,1,0,0,0, 1,0,0,1,32'h0));
        // DEPTH=4: back-pressure fill, drain with wrap, flush priority, global flush.
        vecs.push_back(v(1,0,0,0,32'h0,0,0,0,0, 0,0,0,1,32'h0));
        vecs.push_back(v(1,1,0,0,32'h0,0,0,0,0, 0,0,0,0,32'h0));
        vecs.push_back(v(1,1,1,1,32'h1,0,0,0,0, 1,0,0,0,32'h0));
        vecs.push_back(v(1,1,1,1,32'h2,0,0,0,0, 1,1,1,0,32'h1));
        vecs.push_back(v(1,1,1,1,32'h3,0,0,0,0, 1,1,2,0,32'h1));
        vecs.push_back(v(1,1,1,1,32'h4,0,0,0,0, 1,1,3,0,32'h1));
        vecs.push_back(v(1,1,1,1,32'h5,0,0,0,0, 0,1,4,0,32'h1));
        vecs.push_back(v(1,1,1,1,32'h6,0,0,0,0, 0,1,4,0,32'h1));
        vecs.push_back(v(1,1,1,0,32'h0,1,0,0,0, 0,1,4,0,32'h1));
        vecs.push_back(v(1,1,1,1,32'h7,1,0,0,0, 1,1,3,0,32'h2));
        vecs.push_back(v(1,1,1,1,32'h8,1,0,0,0, 1,1,3,0,32'h3));
        vecs.push_back(v(1,1,1,0,32'h0,1,0,0,0, 1,1,3,0,32'h4));
        vecs.push_back(v(1,1,1,0,32'h0,1,0,0,0, 1,1,2,0,32'h7));
        vecs.push_back(v(1,1,1,0,32'h0,0,0,0,0, 1,1,1,0,32'h8));
        vecs.push_back(v(1,1,1,1,32'h9,0,0,0,0, 1,1,1,0,32'h8));
        vecs.push_back(v(1,1,1,1,32'hA,0,0,0,0, 1,1,2,0,32'h8));
        vecs.push_back(v(1,1,1,1,32'hAAAABBBB,1,1,0,1, 0,0,3,0,32'h8));
        vecs.push_back(v(1,1,1,0,32'h0,0,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(1,1,1,1,32'hB,0,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(1,1,1,1,32'hC,0,0,0,0, 1,1,1,0,32'hB));
        vecs.push_back(v(1,1,1,1,32'hD,0,0,0,0, 1,1,2,0,32'hB));
        vecs.push_back(v(1,1,1,1,32'hAAAABBBB,1,0,1,0, 1,1,3,0,32'hB));
        vecs.push_back(v(1,1,1,0,32'h0,0,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(1,1,1,1,32'hE,0,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(1,1,1,0,32'h0,1,0,0,0, 1,1,1,0,32'hE));
        vecs.push_back(v(1,1,1,0,32'h0,1,0,0,0, 1,0,0,1,32'h0));
        // DEPTH=1: alternating full/empty, one transfer every two cycles.
        vecs.push_back(v(2,0,0,0,32'h0,0,0,0,0, 0,0,0,1,32'h0));
        vecs.push_back(v(2,1,0,1,32'hDEADBEEF,1,0,0,0, 0,0,0,0,32'h0));
        vecs.push_back(v(2,1,1,1,32'h101,1,0,0,0, 1,0,0,0,32'h0));
        vecs.push_back(v(2,1,1,1,32'h102,1,0,0,0, 0,1,1,0,32'h101));
        vecs.push_back(v(2,1,1,1,32'h102,1,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(2,1,1,1,32'h103,1,0,0,0, 0,1,1,0,32'h102));
        vecs.push_back(v(2,1,1,1,32'h103,1,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(2,1,1,1,32'h104,1,0,0,0, 0,1,1,0,32'h103));
        vecs.push_back(v(2,1,1,1,32'h104,1,0,0,0, 1,0,0,1,32'h0));
        vecs.push_back(v(2,1,1,1,32'h105,1,0,0,0, 0,1,1,0,32'h104));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            sel = vecs[i].sel; rst_n = vecs[i].rst; valid_i = vecs[i].vld; data_i = vecs[i].dat;
            ready_i = vecs[i].rdy; flush_i = vecs[i].fl; global_flush_i = vecs[i].gfl;
            global_stall_i = vecs[i].stl;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d.ready_o", i), 32'(o_rdy), 32'(vecs[i].e_rdy));
                check($sformatf("v%0d.valid_o", i), 32'(o_vld), 32'(vecs[i].e_vld));
                check($sformatf("v%0d.count_o", i), 32'(o_cnt), 32'(vecs[i].e_cnt));
                check($sformatf("v%0d.full_o", i), 32'(o_full), 32'(int'(vecs[i].e_cnt) == o_depth));
                check($sformatf("v%0d.empty_o", i), 32'(o_empty), 32'(vecs[i].e_cnt == 8'd0));
                if (!vecs[i].dc) begin
                    check($sformatf("v%0d.data_o", i), o_dat, vecs[i].e_dat);
                end else begin
`ifdef PIPELINE_FLUSH_ZERO_EN
                    check($sformatf("v%0d.data_o_zero", i), o_dat, 32'h0);
`endif
                end
            end
        end

        // DEPTH=1 throughput: valid held high for 8 cycles yields exactly 4 transfers.
        @(negedge clk);
        sel = 2'd2; rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        flush_i = 1'b0; global_flush_i = 1'b0; global_stall_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; valid_i = 1'b1;
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            data_i = 32'h200 + 32'(i);
            #1;
            check($sformatf("d1_seq%0d.ready_o", i), 32'(ready_c), 32'((i % 2) == 0));
            if (valid_c && ready_i) pops++;
            @(negedge clk);
        end
        check("d1_seq.transfers", 32'(pops), 32'd4);
        valid_i = 1'b0;

        // Reset mid-stream on DEPTH=2 drops both held entries and zeroes storage.
        @(negedge clk);
        sel = 2'd0; valid_i = 1'b1; data_i = 32'h55555555; ready_i = 1'b0;
        @(negedge clk);
        data_i = 32'h66666666;
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check("midrst.count_before", 32'(count_a), 32'd2);
        check("midrst.data_before", data_a, 32'h55555555);
        rst_n = 1'b0; ready_i = 1'b1;
        #1;
        check("midrst.ready_in_reset", 32'(ready_a), 32'd0);
        check("midrst.valid_in_reset", 32'(valid_a), 32'd0);
        @(negedge clk);
        #1;
        check("midrst.count_after", 32'(count_a), 32'd0);
        check("midrst.empty_after", 32'(empty_a), 32'd1);
        check("midrst.data_after", data_a, 32'h0);
        rst_n = 1'b1;
        #1;
        check("midrst.ready_release", 32'(ready_a), 32'd1);
        check("midrst.valid_release", 32'(valid_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
